// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Three-way (loader / video DMA / CPU) single-port RAM arbiter
//               with DMA anti-starvation, bounded wait and shared read data.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int DMA_BURST = 8,
  parameter int TIMEOUT   = 63
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_din,
  output logic              ldr_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ack,
  output logic              busy,
  output logic              timeout_err
);

  localparam int RUN_W  = $clog2(DMA_BURST + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  C_RUN_MAX   = RUN_W'(DMA_BURST);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] C_GNT_LDR = 2'd0;
  localparam logic [1:0] C_GNT_DMA = 2'd1;
  localparam logic [1:0] C_GNT_CPU = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [1:0]        r_gnt;
  logic              r_we;
  logic [RUN_W-1:0]  r_dma_run;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic w_cpu_turn;
  logic w_timed_out;
  logic w_finish;

  // After a full DMA burst with the CPU waiting, the CPU jumps ahead of DMA.
  assign w_cpu_turn  = cpu_req && (r_dma_run == C_RUN_MAX);
  assign w_timed_out = !mem_ack && (r_wait_cnt == C_WAIT_LAST);
  assign w_finish    = mem_ack || w_timed_out;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= C_GNT_LDR;
      r_we        <= 1'b0;
      r_dma_run   <= '0;
      r_wait_cnt  <= '0;
      ldr_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      rdata       <= 8'h00;
      mem_addr    <= '0;
      mem_din     <= 8'h00;
      mem_we      <= 1'b0;
      mem_rd      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ldr_ack <= 1'b0;
      dma_ack <= 1'b0;
      cpu_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!cpu_req) r_dma_run <= '0;
          if (ldr_req) begin
            r_gnt    <= C_GNT_LDR;
            r_we     <= 1'b1;
            mem_addr <= ldr_addr;
            mem_din  <= ldr_din;
            mem_we   <= 1'b1;
            r_state  <= S_ISSUE;
          end else if (dma_req && !w_cpu_turn) begin
            r_gnt    <= C_GNT_DMA;
            r_we     <= 1'b0;
            mem_addr <= dma_addr;
            mem_din  <= 8'h00;
            mem_rd   <= 1'b1;
            r_state  <= S_ISSUE;
            if (cpu_req && (r_dma_run != C_RUN_MAX)) r_dma_run <= r_dma_run + 1'b1;
          end else if (cpu_req) begin
            r_gnt     <= C_GNT_CPU;
            r_we      <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_din   <= cpu_din;
            mem_we    <= cpu_we;
            mem_rd    <= !cpu_we;
            r_dma_run <= '0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_we     <= 1'b0;
          mem_rd     <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (w_finish) begin
            // The ack is raised on entry to DONE so it is visible for exactly that cycle.
            ldr_ack <= (r_gnt == C_GNT_LDR);
            dma_ack <= (r_gnt == C_GNT_DMA);
            cpu_ack <= (r_gnt == C_GNT_CPU);
            r_state <= S_DONE;
            if (mem_ack) begin
              if (!r_we) rdata <= mem_dout;
            end else begin
              if (!r_we) rdata <= 8'hFF;
              timeout_err <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 25, width of all address buses.
REQ-002 Parameter DMA_BURST, default 8, maximum consecutive DMA grants while a CPU request waits.
REQ-003 Parameter TIMEOUT, default 63, number of WAIT cycles without mem_ack before the access is abandoned.
REQ-004 Port clk, input, 1, system clock; all logic is on the rising edge.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Ports ldr_req / ldr_addr / ldr_din, inputs, 1 / ADDR_W / 8, loader write request; the loader only writes.
REQ-007 Port ldr_ack, output, 1, one-cycle pulse that completes a loader access.
REQ-008 Ports dma_req / dma_addr, inputs, 1 / ADDR_W, video DMA read request; DMA only reads.
REQ-009 Port dma_ack, output, 1, one-cycle pulse that completes a DMA access.
REQ-010 Ports cpu_req / cpu_we / cpu_addr / cpu_din, inputs, 1 / 1 / ADDR_W / 8, CPU read or write request.
REQ-011 Port cpu_ack, output, 1, one-cycle pulse that completes a CPU access.
REQ-012 Port rdata, output, 8, registered read data, shared by all requesters.
REQ-013 Ports mem_addr / mem_din / mem_we / mem_rd, outputs, ADDR_W / 8 / 1 / 1, memory command.
REQ-014 Ports mem_dout / mem_ack, inputs, 8 / 1, memory read data and one-cycle completion strobe.
REQ-015 Port busy, output, 1, high in every state except IDLE.
REQ-016 Port timeout_err, output, 1, sticky flag set when an access times out.

Function
REQ-017 State machine states are IDLE, ISSUE, WAIT and DONE.
REQ-018 Requests are level-held until the matching ack; at most one ack is high in any cycle.
REQ-019 IDLE, any request pending: latch grant, address, data and write flag; next state is ISSUE.
REQ-020 IDLE, no request pending: remain in IDLE.
REQ-021 Priority is ldr > dma > cpu, except as given in REQ-022.
REQ-022 Anti-starvation: when dma_run == DMA_BURST and cpu_req is high, the CPU wins over DMA; the loader still wins over both.
REQ-023 dma_run increments on each DMA grant made while cpu_req is high, saturating at DMA_BURST.
REQ-024 dma_run clears on any CPU grant and on any cycle in IDLE with cpu_req low.
REQ-025 ISSUE lasts exactly 1 cycle: mem_we (write) or mem_rd (read) is high, mem_addr and mem_din carry the latched values; next state is WAIT.
REQ-026 mem_addr and mem_din stay stable from ISSUE through DONE; mem_we and mem_rd are low outside ISSUE.
REQ-027 WAIT, mem_ack high: capture mem_dout into rdata on reads; next state is DONE.
REQ-028 WAIT, no mem_ack: the wait counter increments.
REQ-029 WAIT, wait counter reaches TIMEOUT: rdata becomes 8'hFF on reads, timeout_err is set, next state is DONE.
REQ-030 mem_ack is ignored outside WAIT.
REQ-031 DONE lasts 1 cycle: pulse the granted requester's ack; next state is IDLE.
REQ-032 Write accesses leave rdata unchanged.
REQ-033 Minimum access time is 4 cycles from the request being seen in IDLE to the ack pulse, with mem_ack arriving in the first WAIT cycle.
REQ-034 A request dropped before its ack still completes the memory cycle, and its ack is still pulsed.

Reset
REQ-035 reset_n low forces, asynchronously: state IDLE, all acks 0, mem_we 0, mem_rd 0, mem_addr 0, mem_din 0, rdata 0, busy 0, timeout_err 0, dma_run 0, wait counter 0.
REQ-036 Reset asserted mid-access abandons the access: no ack is issued, and a late mem_ack is ignored per REQ-030.
REQ-037 After reset_n rises, the first arbitration happens on the next rising edge.

Verification
REQ-038 Scenario: CPU read of 0x00100 with mem_ack 2 cycles after mem_rd and mem_dout = 8'h5A -> a single mem_rd pulse, cpu_ack in the cycle after mem_ack, rdata = 8'h5A.
REQ-039 Scenario: ldr_req, dma_req and cpu_req all raised in the same cycle -> service order ldr, dma, cpu, with exactly 3 acks and no overlap.
REQ-040 Scenario: dma_req and cpu_req held continuously -> exactly 8 DMA acks, then 1 CPU ack, then the pattern repeats.
REQ-041 Scenario: CPU read with mem_ack never asserted -> cpu_ack 63 WAIT cycles later, rdata = 8'hFF, timeout_err = 1 until reset.
REQ-042 Scenario: reset_n pulsed low during WAIT of a loader write -> all outputs 0 immediately, no ldr_ack, and the next request is served normally.
